// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package seven_seg_pkg;

  // Scan FSM states: dark idle, dark guard interval, digit being shown.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

  localparam int BCD_W   = 4;
  localparam int BCD_MAX = 9;

  // True when the code is a legal BCD digit the decoder can render.
  function automatic logic bcd_ok(input logic [BCD_W-1:0] code);
    return code <= BCD_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/seven_seg_scan_timer.sv
// Down-counter that times the dwell and guard intervals; done while count is zero.
// Latency: load/clr take effect on the next clock; done is a decode of the count flop.
// Backpressure: none; it counts freely while neither loaded nor cleared.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - force count to zero (scan disabled)
//   load      - load load_val (interval length minus one)
//   load_val  - value to load
//   done      - high while the count is zero, i.e. in the last cycle of an interval
module seven_seg_scan_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan of an N-digit BCD frame onto one shared decoder, dark guard between digits.
// Latency: all outputs registered; digit 0 lights GUARD+1 cycles after enable rises.
// Backpressure: load_ready = no frame pending; a pending frame is applied only at a frame boundary.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   enable       - scan on; low takes the display dark on the next cycle
//   lzb          - leading-zero blanking
//   load_valid   - new frame offered; load_ready - a frame can be accepted
//   load_digits  - BCD frame, digit 0 in [3:0]; load_dp - decimal-point mask
//   bcd_out      - code to the shared decoder; digit_en - one-hot digit drive
//   dp_out       - decimal point for the driven digit; frame_tick - pulse at each frame swap
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 50000,
  parameter int GUARD      = 500
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        lzb,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_digits,
  input  logic [NUM_DIGITS-1:0]       load_dp,
  output logic [BCD_W-1:0]            bcd_out,
  output logic [NUM_DIGITS-1:0]       digit_en,
  output logic                        dp_out,
  output logic                        frame_tick
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int MAX_LEN = (DWELL > GUARD) ? DWELL : GUARD;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  // The timer's done flag marks the last cycle, so it is loaded with length-1.
  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  scan_state_e state_d, state_q;
  logic [IDX_W-1:0] idx_d, idx_q;

  logic [BCD_W*NUM_DIGITS-1:0] active_dig_d, active_dig_q;
  logic [NUM_DIGITS-1:0]       active_dp_d, active_dp_q;
  logic [BCD_W*NUM_DIGITS-1:0] pend_dig_d, pend_dig_q;
  logic [NUM_DIGITS-1:0]       pend_dp_d, pend_dp_q;
  logic                        pending_d, pending_q;

  logic [BCD_W-1:0]      bcd_d, bcd_q;
  logic [NUM_DIGITS-1:0] en_d, en_q;
  logic                  dp_d, dp_q;
  logic                  tick_d, tick_q;

  logic             swap;
  logic             xfer;
  logic             tmr_clr;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  logic [BCD_W-1:0] code;
  logic             tail_zero;
  logic             blank;

  seven_seg_scan_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Scan sequencing. enable low overrides everything and parks the FSM dark.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    swap     = 1'b0;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      tmr_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_GUARD;
          idx_d    = '0;
          swap     = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = GUARD_LD;
        end
        ST_GUARD: begin
          if (tmr_done) begin
            state_d  = ST_SHOW;
            tmr_load = 1'b1;
            tmr_val  = DWELL_LD;
          end
        end
        ST_SHOW: begin
          if (tmr_done) begin
            state_d  = ST_GUARD;
            tmr_load = 1'b1;
            tmr_val  = GUARD_LD;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              swap  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          tmr_clr = 1'b1;
        end
      endcase
    end
  end

  // Frame buffering. A transfer can only happen with nothing pending, so a
  // frame accepted in a swap cycle waits for the following swap.
  always_comb begin
    xfer         = load_valid && !pending_q;
    active_dig_d = active_dig_q;
    active_dp_d  = active_dp_q;
    pend_dig_d   = pend_dig_q;
    pend_dp_d    = pend_dp_q;
    pending_d    = pending_q;
    if (swap && pending_q) begin
      active_dig_d = pend_dig_q;
      active_dp_d  = pend_dp_q;
      pending_d    = 1'b0;
    end
    if (xfer) begin
      pend_dig_d = load_digits;
      pend_dp_d  = load_dp;
      pending_d  = 1'b1;
    end
  end

  // Output decode from the next state so the registered outputs line up
  // with the state they describe.
  always_comb begin
    code      = active_dig_d[int'(idx_d)*BCD_W +: BCD_W];
    tail_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(idx_d) &&
          (active_dig_d[j*BCD_W +: BCD_W] != '0 || active_dp_d[j])) begin
        tail_zero = 1'b0;
      end
    end
    // A digit with a decimal point at or above it is significant, never a leading zero.
    blank  = !bcd_ok(code) || (lzb && (idx_d != '0) && tail_zero);
    bcd_d  = '0;
    en_d   = '0;
    dp_d   = 1'b0;
    tick_d = swap;
    if (state_d == ST_SHOW && !blank) begin
      bcd_d = code;
      dp_d  = active_dp_d[idx_d];
      en_d  = NUM_DIGITS'(1) << idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      active_dig_q <= '0;
      active_dp_q  <= '0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pending_q    <= 1'b0;
      bcd_q        <= '0;
      en_q         <= '0;
      dp_q         <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      active_dig_q <= active_dig_d;
      active_dp_q  <= active_dp_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pending_q    <= pending_d;
      bcd_q        <= bcd_d;
      en_q         <= en_d;
      dp_q         <= dp_d;
      tick_q       <= tick_d;
    end
  end

  assign load_ready = !pending_q;
  assign bcd_out    = bcd_q;
  assign digit_en   = en_q;
  assign dp_out     = dp_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with a short dwell/guard so whole frames are checked cycle by cycle.
// Latency: n/a.
// Backpressure: n/a.
module tb_seven_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int DW    = 4;
  localparam int GD    = 1;
  localparam int SLOT  = DW + GD;
  localparam int FRAME = N * SLOT;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic           lzb;
  logic           load_valid;
  logic           load_ready;
  logic [4*N-1:0] load_digits;
  logic [N-1:0]   load_dp;
  logic [3:0]     bcd_out;
  logic [N-1:0]   digit_en;
  logic           dp_out;
  logic           frame_tick;

  int total = 0;
  int bad   = 0;

  // Frame to load plus the hand-computed picture it must produce.
  typedef struct {
    logic [15:0] dig;
    logic [3:0]  dp;
    logic        lzb;
    logic [3:0]  lit;   // which digit slots are driven
    logic [15:0] bcd;   // code expected in each lit slot
    logic [3:0]  edp;   // dp expected in each lit slot
  } vec_t;

  vec_t tbl[7];
  vec_t v_zero, v_a, v_b, v_c;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS (N),
    .DWELL      (DW),
    .GUARD      (GD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .lzb         (lzb),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_digits (load_digits),
    .load_dp     (load_dp),
    .bcd_out     (bcd_out),
    .digit_en    (digit_en),
    .dp_out      (dp_out),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%h want=%h", name, t, act, exp);
    end
  endtask

  // Steps until frame_tick is seen; n is the number of steps taken.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (frame_tick !== 1'b1 && n < 200);
    if (frame_tick !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL wait_tick timeout got=%0d steps want=tick", n);
    end
  endtask

  // Called in the cycle frame_tick is high; checks the next whole frame.
  // Packed compare: {digit_en, bcd_out, dp_out, frame_tick, load_ready}.
  task automatic check_frame(input string name, input vec_t v, input logic exp_rdy);
    int p, k;
    logic [3:0] e_en, e_bcd;
    logic       e_dp, e_tick, e_rdy;
    logic [10:0] a, e;
    for (int t = 1; t <= FRAME; t++) begin
      step();
      p = (t - 1) % SLOT;
      k = (t - 1) / SLOT;
      e_en = 4'h0;
      e_bcd = 4'h0;
      e_dp = 1'b0;
      if (p < DW && v.lit[k]) begin
        e_en  = 4'h1 << k;
        e_bcd = v.bcd[k*4 +: 4];
        e_dp  = v.edp[k];
      end
      e_tick = (t == FRAME);
      e_rdy  = (t == FRAME) ? 1'b1 : exp_rdy;
      a = {digit_en, bcd_out, dp_out, frame_tick, load_ready};
      e = {e_en, e_bcd, e_dp, e_tick, e_rdy};
      chk(name, t, 32'(a), 32'(e));
    end
  endtask

  // Called in a tick cycle; offers a frame, then waits for the swap that applies it.
  task automatic offer(input vec_t v);
    int n;
    lzb         = v.lzb;
    load_digits = v.dig;
    load_dp     = v.dp;
    load_valid  = 1'b1;
    step();
    load_valid = 1'b0;
    chk("offer_ready_low", 1, 32'(load_ready), 32'(0));
    wait_tick(n);
    chk("offer_period", n, 32'(n), 32'(FRAME - 1));
  endtask

  initial begin
    int n;
    tbl[0] = '{dig:16'h1234, dp:4'h0, lzb:1'b0, lit:4'hF, bcd:16'h1234, edp:4'h0};
    tbl[1] = '{dig:16'h0070, dp:4'h0, lzb:1'b1, lit:4'h3, bcd:16'h0070, edp:4'h0};
    tbl[2] = '{dig:16'h00A5, dp:4'h0, lzb:1'b0, lit:4'hD, bcd:16'h0005, edp:4'h0};
    tbl[3] = '{dig:16'h0003, dp:4'h4, lzb:1'b1, lit:4'h7, bcd:16'h0003, edp:4'h4};
    tbl[4] = '{dig:16'h9F00, dp:4'h0, lzb:1'b1, lit:4'hB, bcd:16'h9000, edp:4'h0};
    tbl[5] = '{dig:16'h0000, dp:4'h0, lzb:1'b1, lit:4'h1, bcd:16'h0000, edp:4'h0};
    tbl[6] = '{dig:16'h0000, dp:4'h8, lzb:1'b1, lit:4'hF, bcd:16'h0000, edp:4'h8};
    v_zero = '{dig:16'h0000, dp:4'h0, lzb:1'b0, lit:4'hF, bcd:16'h0000, edp:4'h0};
    v_a    = '{dig:16'h5678, dp:4'h0, lzb:1'b0, lit:4'hF, bcd:16'h5678, edp:4'h0};
    v_b    = '{dig:16'h4321, dp:4'h2, lzb:1'b0, lit:4'hF, bcd:16'h4321, edp:4'h2};
    v_c    = '{dig:16'h0808, dp:4'h0, lzb:1'b0, lit:4'hF, bcd:16'h0808, edp:4'h0};

    rst = 1'b1;
    enable = 1'b0;
    lzb = 1'b0;
    load_valid = 1'b0;
    load_digits = '0;
    load_dp = '0;
    repeat (3) step();
    chk("rst_digit_en", 0, 32'(digit_en), 32'(0));
    chk("rst_bcd", 0, 32'(bcd_out), 32'(0));
    chk("rst_dp", 0, 32'(dp_out), 32'(0));
    chk("rst_tick", 0, 32'(frame_tick), 32'(0));
    chk("rst_ready", 0, 32'(load_ready), 32'(1));
    rst = 1'b0;
    step();
    chk("idle_dark", 0, 32'(digit_en), 32'(0));

    // Power-up frame is all zero and shown unblanked with lzb off.
    enable = 1'b1;
    step();
    chk("start_tick", 0, 32'(frame_tick), 32'(1));
    chk("start_dark", 0, 32'(digit_en), 32'(0));
    check_frame("zero_frame", v_zero, 1'b1);

    for (int i = 0; i < 7; i++) begin
      offer(tbl[i]);
      check_frame($sformatf("vec%0d", i), tbl[i], 1'b1);
    end

    // Back-to-back loads with load_valid held high.
    lzb = 1'b0;
    load_digits = v_a.dig;
    load_dp = v_a.dp;
    load_valid = 1'b1;
    step();
    chk("b2b_first_acc", 1, 32'(load_ready), 32'(0));
    load_digits = v_b.dig;
    load_dp = v_b.dp;
    wait_tick(n);
    chk("b2b_period", n, 32'(n), 32'(FRAME - 1));
    chk("b2b_ready_at_swap", 0, 32'(load_ready), 32'(1));
    check_frame("b2b_frame_a", v_a, 1'b0);
    load_valid = 1'b0;
    check_frame("b2b_frame_b", v_b, 1'b1);

    // enable drops while digit 2 is shown, with a frame pending.
    load_digits = v_c.dig;
    load_dp = v_c.dp;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("en_pend_ready", 1, 32'(load_ready), 32'(0));
    repeat (11) step();
    chk("en_d2_shown", 12, 32'(digit_en), 32'(4'b0100));
    chk("en_d2_code", 12, 32'(bcd_out), 32'(3));
    enable = 1'b0;
    step();
    chk("en_off_dark", 0, 32'({digit_en, bcd_out, dp_out, frame_tick}), 32'(0));
    chk("en_off_pend_kept", 0, 32'(load_ready), 32'(0));
    repeat (3) step();
    chk("en_off_idle", 0, 32'({digit_en, frame_tick}), 32'(0));
    enable = 1'b1;
    step();
    chk("reen_tick", 0, 32'(frame_tick), 32'(1));
    chk("reen_ready", 0, 32'(load_ready), 32'(1));
    chk("reen_dark", 0, 32'(digit_en), 32'(0));
    check_frame("reen_frame_c", v_c, 1'b1);

    // Reset mid-frame with a frame pending: pending and active frame both discarded.
    load_digits = 16'h1111;
    load_dp = 4'hF;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    repeat (6) step();
    chk("mid_d1_shown", 7, 32'(digit_en), 32'(4'b0010));
    rst = 1'b1;
    step();
    chk("midrst_outputs", 0, 32'({digit_en, bcd_out, dp_out, frame_tick, load_ready}), 32'(1));
    rst = 1'b0;
    step();
    chk("midrst_restart_tick", 0, 32'(frame_tick), 32'(1));
    check_frame("midrst_zero_frame", v_zero, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
